target_generator: RTL and testbench

//  Produces the food/target cell (TARGET_ADDR_H/V) consumed by the snake control stage and re-places it

---
 rtl/snake_pkg.sv | 27 ++
 rtl/target_lfsr.sv | 21 ++
 rtl/target_generator.sv | 128 ++++++++++++
 tb/tb_target_generator.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: master-state codes, grid limits,
// cell coordinate widths and the target generator's LFSR polynomials.
package snake_pkg;

    typedef enum logic [1:0] {
        MSM_IDLE = 2'b00,
        MSM_PLAY = 2'b01,
        MSM_WIN  = 2'b10,
        MSM_LOSE = 2'b11
    } msm_state_t;

    typedef enum logic {
        GEN_HOLD   = 1'b0,
        GEN_SEARCH = 1'b1
    } gen_state_t;

    localparam int CELL_X_W = 8;
    localparam int CELL_Y_W = 7;

    localparam logic [CELL_X_W-1:0] GRID_MAX_X = 8'd159;
    localparam logic [CELL_Y_W-1:0] GRID_MAX_Y = 7'd119;

    // Feedback tap masks: x^8+x^6+x^5+x^4+1 and x^7+x^6+1
    localparam logic [CELL_X_W-1:0] LFSR_X_TAPS = 8'b1011_1000;
    localparam logic [CELL_Y_W-1:0] LFSR_Y_TAPS = 7'b110_0000;

endpackage

// File: rtl/target_lfsr.sv
// Free-running Fibonacci LFSR; shifts toward the MSB with the XOR of the tapped bits
// entering at bit 0. Steps on every cycle that is not in reset.
module target_lfsr #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic [WIDTH-1:0] state
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SEED;
        end else begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

endmodule

// File: rtl/target_generator.sv
// Places the food cell for the snake control stage: re-searches on a rising
// TARGET_REACHED in PLAY, rejecting off-grid and head-cell candidates.
module target_generator
    import snake_pkg::*;
#(
    parameter logic [CELL_X_W-1:0] MAX_X     = GRID_MAX_X,
    parameter logic [CELL_Y_W-1:0] MAX_Y     = GRID_MAX_Y,
    parameter logic [CELL_X_W-1:0] INIT_X    = 8'd40,
    parameter logic [CELL_Y_W-1:0] INIT_Y    = 7'd30,
    parameter logic [CELL_X_W-1:0] SEED_X    = 8'hA5,
    parameter logic [CELL_Y_W-1:0] SEED_Y    = 7'h2B,
    parameter int                  MAX_TRIES = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [1:0]          MSM_STATE,
    input  logic                TARGET_REACHED,
    input  logic [CELL_X_W-1:0] HEAD_X,
    input  logic [CELL_Y_W-1:0] HEAD_Y,
    output logic [CELL_X_W-1:0] TARGET_ADDR_H,
    output logic [CELL_Y_W-1:0] TARGET_ADDR_V,
    output logic                TARGET_VALID,
    output logic                NEW_TARGET
);

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    logic [CELL_X_W-1:0] lfsr_x;
    logic [CELL_Y_W-1:0] lfsr_y;
    logic                reach_q;
    logic                trig;
    gen_state_t          state, state_nxt;
    logic [7:0]          tries, tries_nxt;
    logic [CELL_X_W-1:0] tgt_x_nxt, forced_x_raw, forced_x;
    logic [CELL_Y_W-1:0] tgt_y_nxt, forced_y;
    logic                valid_nxt, new_nxt;
    logic                cand_ok;

    target_lfsr #(.WIDTH(CELL_X_W), .TAPS(LFSR_X_TAPS), .SEED(SEED_X)) u_lfsr_x (
        .CLK   (CLK),
        .RESET (RESET),
        .state (lfsr_x)
    );

    target_lfsr #(.WIDTH(CELL_Y_W), .TAPS(LFSR_Y_TAPS), .SEED(SEED_Y)) u_lfsr_y (
        .CLK   (CLK),
        .RESET (RESET),
        .state (lfsr_y)
    );

    assign trig    = TARGET_REACHED && !reach_q && (MSM_STATE == MSM_PLAY);
    assign cand_ok = (lfsr_x <= MAX_X) && (lfsr_y <= MAX_Y) &&
                     !((lfsr_x == HEAD_X) && (lfsr_y == HEAD_Y));

    // Masked fallback cell; stepping one column right dodges the head and stays <= 128
    assign forced_x_raw = {1'b0, lfsr_x[6:0]};
    assign forced_y     = {1'b0, lfsr_y[5:0]};
    assign forced_x     = ((forced_x_raw == HEAD_X) && (forced_y == HEAD_Y)) ?
                          forced_x_raw + 8'd1 : forced_x_raw;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= GEN_HOLD;
            tries         <= '0;
            reach_q       <= 1'b0;
            TARGET_ADDR_H <= INIT_X;
            TARGET_ADDR_V <= INIT_Y;
            TARGET_VALID  <= 1'b1;
            NEW_TARGET    <= 1'b0;
        end else begin
            state         <= state_nxt;
            tries         <= tries_nxt;
            reach_q       <= TARGET_REACHED;
            TARGET_ADDR_H <= tgt_x_nxt;
            TARGET_ADDR_V <= tgt_y_nxt;
            TARGET_VALID  <= valid_nxt;
            NEW_TARGET    <= new_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tries_nxt = tries;
        tgt_x_nxt = TARGET_ADDR_H;
        tgt_y_nxt = TARGET_ADDR_V;
        valid_nxt = TARGET_VALID;
        new_nxt   = 1'b0;
        case (state)
            GEN_HOLD: begin
                if (trig) begin
                    state_nxt = GEN_SEARCH;
                    valid_nxt = 1'b0;
                    tries_nxt = '0;
                end else if (MSM_STATE == MSM_IDLE) begin
                    tgt_x_nxt = INIT_X;
                    tgt_y_nxt = INIT_Y;
                end
            end
            GEN_SEARCH: begin
                // Leaving PLAY abandons the search before any candidate is considered
                if (MSM_STATE != MSM_PLAY) begin
                    state_nxt = GEN_HOLD;
                    valid_nxt = 1'b1;
                    if (MSM_STATE == MSM_IDLE) begin
                        tgt_x_nxt = INIT_X;
                        tgt_y_nxt = INIT_Y;
                    end
                end else if (cand_ok) begin
                    state_nxt = GEN_HOLD;
                    tgt_x_nxt = lfsr_x;
                    tgt_y_nxt = lfsr_y;
                    valid_nxt = 1'b1;
                    new_nxt   = 1'b1;
                end else if (tries == LAST_TRY) begin
                    state_nxt = GEN_HOLD;
                    tgt_x_nxt = forced_x;
                    tgt_y_nxt = forced_y;
                    valid_nxt = 1'b1;
                    new_nxt   = 1'b1;
                end else begin
                    tries_nxt = tries + 8'd1;
                end
            end
            default: state_nxt = GEN_HOLD;
        endcase
    end

endmodule

// File: tb/tb_target_generator.sv
// Bench for target_generator: a default instance and a short-budget instance
// (MAX_TRIES=4) driven in lockstep, compared against a sequence-indexed model.
module tb_target_generator;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] MSM_STATE = 2'b01;
    logic       TARGET_REACHED = 1'b0;
    logic [7:0] HEAD_X = 8'd80;
    logic [6:0] HEAD_Y = 7'd100;

    logic [7:0] a_h, b_h;
    logic [6:0] a_v, b_v;
    logic       a_valid, a_new, b_valid, b_new;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] xs [255];
    logic [6:0] ys [127];

    typedef struct {
        logic [7:0] tx;
        logic [6:0] ty;
        logic       valid;
        logic       newt;
        logic       busy;
        logic       prev_tr;
        logic [7:0] lhx;
        logic [6:0] lhy;
        int         used;
        int         k;
    } model_t;

    model_t ma, mb;

    target_generator dut_a (
        .CLK(CLK), .RESET(RESET), .MSM_STATE(MSM_STATE), .TARGET_REACHED(TARGET_REACHED),
        .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .TARGET_ADDR_H(a_h), .TARGET_ADDR_V(a_v),
        .TARGET_VALID(a_valid), .NEW_TARGET(a_new)
    );

    target_generator #(.MAX_TRIES(4)) dut_b (
        .CLK(CLK), .RESET(RESET), .MSM_STATE(MSM_STATE), .TARGET_REACHED(TARGET_REACHED),
        .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .TARGET_ADDR_H(b_h), .TARGET_ADDR_V(b_v),
        .TARGET_VALID(b_valid), .NEW_TARGET(b_new)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.tx = 8'd40; m.ty = 7'd30; m.valid = 1'b1; m.newt = 1'b0; m.busy = 1'b0;
        m.prev_tr = 1'b0; m.lhx = '0; m.lhy = '0; m.used = 0; m.k = 0;
        return m;
    endfunction

    // One clock of the game rules; k is the position in both LFSR sequences
    function automatic model_t model_next(model_t s, int budget, logic rst, logic [1:0] msm,
                                          logic tr, logic [7:0] hx, logic [6:0] hy);
        model_t     n;
        logic [7:0] cx, fx;
        logic [6:0] cy, fy;
        if (rst) return model_reset();
        n = s;
        n.k = s.k + 1;
        n.prev_tr = tr;
        n.newt = 1'b0;
        n.lhx = hx;
        n.lhy = hy;
        cx = xs[s.k % 255];
        cy = ys[s.k % 127];
        if (!s.busy) begin
            if (msm == 2'b01 && tr && !s.prev_tr) begin
                n.busy = 1'b1; n.valid = 1'b0; n.used = 0;
            end else if (msm == 2'b00) begin
                n.tx = 8'd40; n.ty = 7'd30;
            end
        end else if (msm != 2'b01) begin
            n.busy = 1'b0; n.valid = 1'b1;
            if (msm == 2'b00) begin n.tx = 8'd40; n.ty = 7'd30; end
        end else if (cx <= 8'd159 && cy <= 7'd119 && (cx != hx || cy != hy)) begin
            n.busy = 1'b0; n.valid = 1'b1; n.newt = 1'b1; n.tx = cx; n.ty = cy;
        end else if (s.used + 1 >= budget) begin
            fx = {1'b0, cx[6:0]};
            fy = {1'b0, cy[5:0]};
            if (fx == hx && fy == hy) fx = fx + 8'd1;
            n.busy = 1'b0; n.valid = 1'b1; n.newt = 1'b1; n.tx = fx; n.ty = fy;
        end else begin
            n.used = s.used + 1;
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        ma <= model_next(ma, 16, RESET, MSM_STATE, TARGET_REACHED, HEAD_X, HEAD_Y);
        mb <= model_next(mb, 4, RESET, MSM_STATE, TARGET_REACHED, HEAD_X, HEAD_Y);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("A.addr_h", a_h, ma.tx);
            check("A.addr_v", a_v, ma.ty);
            check("A.valid", a_valid, ma.valid);
            check("A.new", a_new, ma.newt);
            check("B.addr_h", b_h, mb.tx);
            check("B.addr_v", b_v, mb.ty);
            check("B.valid", b_valid, mb.valid);
            check("B.new", b_new, mb.newt);
            if (a_new) begin
                check("A.range_h", a_h <= 8'd159, 1);
                check("A.range_v", a_v <= 7'd119, 1);
                check("A.not_head", (a_h == ma.lhx) && (a_v == ma.lhy), 0);
            end
            if (b_new) begin
                check("B.range_h", b_h <= 8'd159, 1);
                check("B.range_v", b_v <= 7'd119, 1);
                check("B.not_head", (b_h == mb.lhx) && (b_v == mb.lhy), 0);
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic exp_a(input string tag, input logic [7:0] h, input logic [6:0] v,
                         input logic vl, input logic nw);
        check({tag, ".A.h"}, a_h, h);
        check({tag, ".A.v"}, a_v, v);
        check({tag, ".A.valid"}, a_valid, vl);
        check({tag, ".A.new"}, a_new, nw);
    endtask

    task automatic exp_b(input string tag, input logic [7:0] h, input logic [6:0] v,
                         input logic vl, input logic nw);
        check({tag, ".B.h"}, b_h, h);
        check({tag, ".B.v"}, b_v, v);
        check({tag, ".B.valid"}, b_valid, vl);
        check({tag, ".B.new"}, b_new, nw);
    endtask

    // Holds reset for n cycles; returns at the negedge where the caller releases it
    task automatic reset_dut(input int n);
        RESET = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            exp_a("rst", 8'd40, 7'd30, 1'b1, 1'b0);
            exp_b("rst", 8'd40, 7'd30, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] p;
        logic [6:0] q;
        int         pulses;
        int         cyc;
        int         commits;
        int         r;

        xs[0] = 8'hA5;
        ys[0] = 7'h2B;
        for (int i = 1; i < 255; i++) begin
            p = xs[i-1];
            xs[i] = {p[6:0], p[8-8+7] ^ p[6-1] ^ p[5-1] ^ p[4-1]};
        end
        for (int i = 1; i < 127; i++) begin
            q = ys[i-1];
            ys[i] = {q[5:0], q[7-1] ^ q[6-1]};
        end

        tick();
        chk_en = 1'b1;

        // Hand-derived sequence positions
        check("pin.x1", xs[1], 8'h4A);
        check("pin.x5", xs[5], 8'hA9);
        check("pin.x9", xs[9], 8'h9D);
        check("pin.y1", ys[1], 7'h57);
        check("pin.y9", ys[9], 7'h70);

        // Reset with the reach line already high, then a level held for 50 cycles
        MSM_STATE = 2'b01;
        TARGET_REACHED = 1'b1;
        HEAD_X = 8'd80; HEAD_Y = 7'd100;
        reset_dut(3);
        RESET = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (a_new) pulses++;
            if (i == 1) exp_a("s2.k1", 8'd40, 7'd30, 1'b0, 1'b0);
            if (i == 2) begin
                exp_a("s2.k2", 8'd74, 7'd87, 1'b1, 1'b1);
                exp_b("s2.k2", 8'd74, 7'd87, 1'b1, 1'b1);
            end
        end
        check("s2.pulses", pulses, 1);

        // Head sits on the first candidate, so the following one is taken
        TARGET_REACHED = 1'b0;
        HEAD_X = 8'd149; HEAD_Y = 7'd47;
        reset_dut(3);
        RESET = 1'b0;
        tick();
        TARGET_REACHED = 1'b1;
        tick();
        exp_a("s3.k2", 8'd40, 7'd30, 1'b0, 1'b0);
        tick();
        exp_a("s3.k3", 8'd40, 7'd30, 1'b0, 1'b0);
        tick();
        exp_a("s3.k4", 8'd42, 7'd95, 1'b1, 1'b1);
        exp_b("s3.k4", 8'd42, 7'd95, 1'b1, 1'b1);

        // Four off-grid candidates in a row: B forces, A keeps looking
        for (int pass = 0; pass < 2; pass++) begin
            TARGET_REACHED = 1'b0;
            HEAD_X = (pass == 0) ? 8'd80 : 8'd78;
            HEAD_Y = (pass == 0) ? 7'd100 : 7'd56;
            reset_dut(2);
            RESET = 1'b0;
            repeat (4) tick();
            TARGET_REACHED = 1'b1;
            for (int k = 5; k <= 8; k++) begin
                tick();
                check("s4.B.valid_low", b_valid, 0);
                check("s4.A.valid_low", a_valid, 0);
            end
            tick();
            exp_b("s4.k9", (pass == 0) ? 8'd78 : 8'd79, 7'd56, 1'b1, 1'b1);
            exp_a("s4.k9", 8'd40, 7'd30, 1'b0, 1'b0);
            tick();
            exp_a("s4.k10", 8'd157, 7'd112, 1'b1, 1'b1);
            exp_b("s4.k10", (pass == 0) ? 8'd78 : 8'd79, 7'd56, 1'b1, 1'b0);
        end

        // Aborts: to WIN keeps the target, to IDLE reloads it; trig in LOSE ignored
        TARGET_REACHED = 1'b1;
        HEAD_X = 8'd80; HEAD_Y = 7'd100;
        reset_dut(2);
        RESET = 1'b0;
        tick(); tick();
        exp_a("s5.k2", 8'd74, 7'd87, 1'b1, 1'b1);
        TARGET_REACHED = 1'b0;
        tick(); tick();
        TARGET_REACHED = 1'b1;
        tick(); tick();
        MSM_STATE = 2'b10;
        tick();
        exp_a("s5.k7", 8'd74, 7'd87, 1'b1, 1'b0);
        exp_b("s5.k7", 8'd74, 7'd87, 1'b1, 1'b0);
        MSM_STATE = 2'b01;
        TARGET_REACHED = 1'b0;
        tick();
        TARGET_REACHED = 1'b1;
        tick(); tick();
        exp_a("s5.k10", 8'd157, 7'd112, 1'b1, 1'b1);
        TARGET_REACHED = 1'b0;
        tick();
        TARGET_REACHED = 1'b1;
        tick();
        MSM_STATE = 2'b00;
        tick();
        exp_a("s5.k13", 8'd40, 7'd30, 1'b1, 1'b0);
        exp_b("s5.k13", 8'd40, 7'd30, 1'b1, 1'b0);
        MSM_STATE = 2'b11;
        TARGET_REACHED = 1'b0;
        tick();
        TARGET_REACHED = 1'b1;
        tick();
        exp_a("s5.k15", 8'd40, 7'd30, 1'b1, 1'b0);
        tick();
        exp_a("s5.k16", 8'd40, 7'd30, 1'b1, 1'b0);

        // Reset in the middle of a search restores outputs and LFSR seeds
        MSM_STATE = 2'b01;
        TARGET_REACHED = 1'b0;
        reset_dut(2);
        RESET = 1'b0;
        repeat (4) tick();
        TARGET_REACHED = 1'b1;
        tick(); tick();
        RESET = 1'b1;
        tick();
        exp_a("s6.rst", 8'd40, 7'd30, 1'b1, 1'b0);
        exp_b("s6.rst", 8'd40, 7'd30, 1'b1, 1'b0);
        RESET = 1'b0;
        tick(); tick();
        exp_a("s6.k2", 8'd74, 7'd87, 1'b1, 1'b1);

        // Random play, often steering HEAD onto the live or forced candidate
        cyc = 0;
        commits = 0;
        while (commits < 3000 && cyc < 60000) begin
            r = int'($urandom_range(0, 99));
            TARGET_REACHED = 1'($urandom_range(0, 1));
            MSM_STATE = (r < 92) ? 2'b01 : (r < 95) ? 2'b00 : (r < 97) ? 2'b10 : 2'b11;
            r = int'($urandom_range(0, 2));
            if (r == 0) begin
                HEAD_X = xs[ma.k % 255];
                HEAD_Y = ys[ma.k % 127];
            end else if (r == 1) begin
                p = xs[mb.k % 255];
                q = ys[mb.k % 127];
                HEAD_X = {1'b0, p[6:0]};
                HEAD_Y = {1'b0, q[5:0]};
            end else begin
                HEAD_X = 8'($urandom_range(0, 255));
                HEAD_Y = 7'($urandom_range(0, 127));
            end
            RESET = ($urandom_range(0, 999) == 0);
            tick();
            cyc++;
            if (a_new) commits++;
        end
        check("rand.commits", commits >= 3000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
